pe_mac_seq: RTL
===============

# pe_mac_seq

Parametrised sequential multiply-accumulate processing element for the systolic array, the next-generation PE. Computes `result <= result + a*b` on signed operands with a multi-cycle shift-and-add multiplier. Operand width, accumulator width and multiplier bits consumed per cycle are configurable. Adds a valid/ready input handshake, accumulator clear, operand forwarding to the neighbour PE, a sticky overflow flag and optional saturation.

## Interface
Parameters:
- DATA_W, 8, operand width (signed, two's complement)
- ACC_W, 24, accumulator width; must be ≥ 2*DATA_W
- STEP, 1, multiplier bits consumed per CALC cycle; must divide DATA_W; N = DATA_W/STEP

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand pair offered
- in_ready  out  1  PE can accept; high exactly when state==IDLE and rst low
- in_data1  in  DATA_W  signed multiplicand a
- in_data2  in  DATA_W  signed multiplier b
- acc_clr  in  1  sampled only on accept; 1 = start accumulation from zero
- result  out  ACC_W  signed accumulator
- done  out  1  one-cycle pulse; result/out_data valid
- out_data1  out  DATA_W  a of the completed operation, forwarded to neighbour
- out_data2  out  DATA_W  b of the completed operation, forwarded to neighbour
- overflow  out  1  sticky, set when any accumulation exceeded signed ACC_W range

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: on `in_valid && in_ready`, the PE:
  - captures |a| and |b| into DATA_W+1-bit registers, so -2^(DATA_W-1) is handled correctly;
  - captures sign = a[MSB] ^ b[MSB], the raw a and b for forwarding, and the acc_clr bit;
  - clears the partial product and the step counter, then goes to CALC.
- CALC: each cycle adds (|a| * next STEP bits of |b|) << (STEP*counter) to the 2*DATA_W-bit partial product. After N cycles, goes to DONE.
- DONE: one cycle, then returns to IDLE.
- Result update (written on the edge entering DONE):
  - p = sign ? -partial : partial, sign-extended to ACC_W+1 bits.
  - base = acc_clr_captured ? 0 : result.
  - sum = base + p, computed at ACC_W+1 bits.
- Overflow: sum is outside [-2^(ACC_W-1), 2^(ACC_W-1)-1] → overflow set. The result value then depends on PE_SAT_EN (see Configuration).
- overflow clears only on rst or on an accepted op with acc_clr=1. The same op may set it again.
- out_data1/out_data2 update on the same edge as result. They hold their value otherwise.
- Inputs are ignored outside the accept cycle. Operands may change freely during CALC.
- in_valid while in_ready is low is not queued.

## Timing
- Reset: state IDLE; result=0, done=0, out_data1=0, out_data2=0, overflow=0. in_ready=0 while rst is high and 1 in the first cycle after rst falls.
- Accept in cycle k → CALC in cycles k+1..k+N → DONE in cycle k+N+1.
  - done=1 and the new result are visible in cycle k+N+1.
  - in_ready=1 again in cycle k+N+2.
- Latency from accept to done is N+1 cycles. Throughput is one op per N+2 cycles.
- done is high for exactly one cycle per accepted op; it never fires without an accept.
- rst mid-operation (CALC or DONE): the op is aborted, no done pulse, and all outputs return to their reset values on the next edge.
- rst and in_valid in the same cycle: rst wins, nothing is accepted.

## Configuration
- PE_SAT_EN defined: on overflow, result clamps to 2^(ACC_W-1)-1 (positive overflow) or -2^(ACC_W-1) (negative overflow).
- PE_SAT_EN undefined: result takes the low ACC_W bits of sum (wrap-around).
- overflow flag behaviour is identical in both builds.

## Test plan
- Defaults (N=8). After reset, send 3 * -4 (in_data2=0xFC) in cycle 0 → in_ready low cycles 1-9; done high only in cycle 9; result=-12, out_data1=3, out_data2=0xFC; in_ready high in cycle 10.
- -128 * -128 with acc_clr=1 → result=16384, overflow=0. Then -128 * 127 with acc_clr=0 → result=128. Repeat with STEP=2: done 5 cycles after accept.
- 5*7 with acc_clr=1 → 35. Then 10 * -2 with acc_clr=0 → 15. Then 2*2 with acc_clr=1 → 4.
- in_valid held high, operands toggled every cycle → an accept every 10 cycles. Each result uses only the operands present on its accept cycle.
- ACC_W=16: 127*127 three times, first with acc_clr=1 → 16129, then 32258.
  - Third op with PE_SAT_EN: result=32767, overflow=1.
  - Third op without PE_SAT_EN: result=-17149, overflow=1.
  - Next accept with acc_clr=1 and 1*1 → result=1, overflow=0.
- Accept 9*9, then assert rst in cycle 4 for one cycle → no done pulse; result=0; in_ready=1 in the cycle after rst falls; a new 2*3 op yields 6.

Source files
------------

// File: rtl/pe_mac_seq.sv
// pe_mac_seq: sequential signed multiply-accumulate processing element.
// A shift-and-add multiplier consumes STEP bits of |b| per CALC cycle, so one
// op takes DATA_W/STEP + 2 cycles from accept to the next accept. Operands of
// the completed op are forwarded to the neighbour PE alongside the result.
// Optional build macro PE_SAT_EN: saturate the accumulator on overflow instead
// of wrapping. Without it, the result keeps the low ACC_W bits of the sum.
module pe_mac_seq #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int STEP   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic              acc_clr,
    output logic [ACC_W-1:0]  result,
    output logic              done,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic              overflow
);

    localparam int N     = DATA_W / STEP;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int PW    = 2 * DATA_W;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [PW-1:0]     mcand;      // |a|, pre-shifted to the current step position
    logic [DATA_W-1:0] mplier;     // |b|, consumed from the LSB end
    logic [PW-1:0]     partial;
    logic              sign_q;
    logic              clr_q;
    logic [DATA_W-1:0] raw_a, raw_b;

    logic              accept;
    logic              last_step;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic [PW-1:0]     term;
    logic [PW-1:0]     partial_nxt;
    logic [ACC_W:0]    p_mag, p_signed, base, sum;
    logic              ovf_now;
    logic [ACC_W-1:0]  res_nxt;

    assign in_ready  = (state == IDLE) && !rst;
    assign done      = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last_step = (cnt == CNT_W'(N - 1));

    // Magnitudes as unsigned DATA_W values: -2^(DATA_W-1) maps to 2^(DATA_W-1),
    // which still fits, so the most negative operand needs no special case.
    assign a_mag = in_data1[DATA_W-1] ? (~in_data1 + 1'b1) : in_data1;
    assign b_mag = in_data2[DATA_W-1] ? (~in_data2 + 1'b1) : in_data2;

    // Shift-and-add step and the signed accumulate that lands on the DONE edge
    always_comb begin
        term        = mcand * PW'(mplier[STEP-1:0]);
        partial_nxt = partial + term;
        p_mag       = {{(ACC_W + 1 - PW){1'b0}}, partial_nxt};
        p_signed    = sign_q ? (~p_mag + 1'b1) : p_mag;
        base        = clr_q ? '0 : {result[ACC_W-1], result};
        sum         = base + p_signed;
        // One guard bit: disagreement with the ACC_W sign bit means out of range
        ovf_now     = sum[ACC_W] ^ sum[ACC_W-1];
`ifdef PE_SAT_EN
        if (ovf_now)
            res_nxt = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            res_nxt = sum[ACC_W-1:0];
`else
        res_nxt = sum[ACC_W-1:0];
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: accept -> N multiply steps -> one done cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = CALC;
            CALC:    if (last_step) state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture on accept, multiply steps, result/forward update
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            partial   <= '0;
            sign_q    <= 1'b0;
            clr_q     <= 1'b0;
            raw_a     <= '0;
            raw_b     <= '0;
            result    <= '0;
            out_data1 <= '0;
            out_data2 <= '0;
            overflow  <= 1'b0;
        end else if (accept) begin
            mcand   <= PW'(a_mag);
            mplier  <= b_mag;
            sign_q  <= in_data1[DATA_W-1] ^ in_data2[DATA_W-1];
            raw_a   <= in_data1;
            raw_b   <= in_data2;
            clr_q   <= acc_clr;
            partial <= '0;
            cnt     <= '0;
            // A fresh accumulation starts with a clean flag; this op may set it again
            if (acc_clr) overflow <= 1'b0;
        end else if (state == CALC) begin
            partial <= partial_nxt;
            mcand   <= mcand << STEP;
            mplier  <= mplier >> STEP;
            cnt     <= cnt + 1'b1;
            if (last_step) begin
                result    <= res_nxt;
                out_data1 <= raw_a;
                out_data2 <= raw_b;
                if (ovf_now) overflow <= 1'b1;
            end
        end
    end

endmodule
